// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave oven controller.
package microwave_pkg;

  // State codes are visible on state_o, so the encoding is fixed.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSetting = 3'd1,
    StCooking = 3'd2,
    StPaused  = 3'd3,
    StDone    = 3'd4
  } state_e;

  // Quick-start cook time in BCD seconds.
  localparam logic [7:0] QuickSecsDefault = 8'h30;

  // Wrap values used when a BCD digit borrows.
  localparam logic [3:0] WrapNine = 4'd9;
  localparam logic [3:0] WrapFive = 4'd5;

  // Decrement one BCD digit; returns {borrow, new_digit}.
  function automatic logic [4:0] bcd_dec_digit(input logic [3:0] digit,
                                               input logic [3:0] wrap);
    logic [4:0] res;
    if (digit == 4'd0) begin
      res = {1'b1, wrap};
    end else begin
      res = {1'b0, digit - 4'd1};
    end
    return res;
  endfunction

  // Decrement an MM:SS BCD time by one second.
  function automatic logic [15:0] bcd_dec_time(input logic [15:0] t);
    logic [4:0] sec_ones;
    logic [4:0] sec_tens;
    logic [4:0] min_ones;
    logic [3:0] min_tens;
    sec_ones = bcd_dec_digit(t[3:0], WrapNine);
    sec_tens = sec_ones[4] ? bcd_dec_digit(t[7:4], WrapFive) : {1'b0, t[7:4]};
    min_ones = sec_tens[4] ? bcd_dec_digit(t[11:8], WrapNine) : {1'b0, t[11:8]};
    if (min_ones[4]) begin
      min_tens = (t[15:12] == 4'd0) ? WrapNine : t[15:12] - 4'd1;
    end else begin
      min_tens = t[15:12];
    end
    return {min_tens, min_ones[3:0], sec_tens[3:0], sec_ones[3:0]};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to one tick per TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Tick on the enabled cycle where the count wraps.
  assign tick = enable && !clear && (cnt_q == CntMax);

  // Count only while enabled; clear wins, disabled cycles hold the count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/microwave_controller.sv
// Microwave oven sequencer: keypad time entry, countdown cooking with door
// interlock, pause/cancel handling and the end-of-cook beep.
module microwave_controller
  import microwave_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned BEEP_SECS  = 3,
  parameter logic [7:0]  QUICK_SECS = QuickSecsDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        cancel,
  input  logic        door_closed,
  output logic [15:0] time_bcd,
  output logic        magnetron_on,
  output logic        beep,
  output logic [2:0]  state_o
);

  localparam int unsigned BeepCycles = BEEP_SECS * TICK_DIV;
  localparam int unsigned BeepW = (BeepCycles > 1) ? $clog2(BeepCycles) : 1;
  localparam logic [BeepW-1:0] BeepLast = BeepW'(BeepCycles - 1);

  state_e           state_q;
  logic [15:0]      time_q;
  logic [BeepW-1:0] beep_cnt_q;

  logic        time_zero;
  logic        digit_ok;
  logic        start_ok;
  logic        cook_start;
  logic        cook_run;
  logic        tick;
  logic [15:0] time_dec;

  // Input qualification for the current cycle.
  always_comb begin
    time_zero = (time_q == 16'h0000);
    // Digit accepted only if the display has room and the new sec_tens stays <= 5.
    digit_ok  = key_valid && (key_digit <= 4'd9) && (time_q[15:12] == 4'd0) &&
                (time_q[3:0] <= 4'd5);
    start_ok  = start && door_closed;
    // Fresh cook from IDLE/SETTING: also restarts the prescaler.
    cook_start = !cancel && start_ok &&
                 (((state_q == StIdle) && time_zero) ||
                  ((state_q == StSetting) && !time_zero));
    // Countdown advances only while cooking with the door shut and no pause request.
    cook_run  = (state_q == StCooking) && door_closed && !cancel;
    time_dec  = bcd_dec_time(time_q);
  end

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (cook_start),
    .enable (cook_run),
    .tick   (tick)
  );

  // Main sequencing FSM; cancel beats start beats key entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      time_q     <= 16'h0000;
      beep_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StSetting: begin
          if (cancel) begin
            if (state_q == StSetting) begin
              state_q <= StIdle;
              time_q  <= 16'h0000;
            end
          end else if (start) begin
            if (cook_start) begin
              if (state_q == StIdle) begin
                time_q <= {8'h00, QUICK_SECS};
              end
              state_q <= StCooking;
            end
          end else if (digit_ok) begin
            time_q  <= {time_q[11:0], key_digit};
            state_q <= StSetting;
          end
        end

        StCooking: begin
          if (cancel || !door_closed) begin
            state_q <= StPaused;
          end else if (tick) begin
            time_q <= time_dec;
            if (time_dec == 16'h0000) begin
              state_q    <= StDone;
              beep_cnt_q <= '0;
            end
          end
        end

        StPaused: begin
          if (cancel) begin
            state_q <= StIdle;
            time_q  <= 16'h0000;
          end else if (start_ok) begin
            state_q <= StCooking;
          end
        end

        StDone: begin
          if (cancel || (beep_cnt_q == BeepLast)) begin
            state_q    <= StIdle;
            beep_cnt_q <= '0;
          end else begin
            beep_cnt_q <= beep_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q    <= StIdle;
          time_q     <= 16'h0000;
          beep_cnt_q <= '0;
        end
      endcase
    end
  end

  // Outputs; the magnetron is gated by the live door level so it drops at once.
  always_comb begin
    time_bcd     = time_q;
    state_o      = state_q;
    beep         = (state_q == StDone);
    magnetron_on = (state_q == StCooking) && door_closed;
  end

endmodule
